frontier_sysid_reader: RTL and testbench

Avalon-MM read initiator for the system-ID slave. On a start pulse it reads word 0 (ID) and word 1 (build timestamp), captures both, and compares them to expected constants. Sits beside the boot/config controller, which holds off software release until sysid_ok. Handles waitrequest back-pressure, readdatavalid responses and a bounded response timeout.

---
 rtl/frontier_sysid_pkg.sv | 8 +
 rtl/frontier_avm_read_port.sv | 46 ++++
 rtl/frontier_sysid_reader.sv | 127 ++++++++++++
 tb/tb_frontier_sysid_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/frontier_sysid_pkg.sv
// frontier_sysid_pkg: FSM state encoding, sysid word addresses and default expected values
package frontier_sysid_pkg;
    typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN} state_t;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'd12345;
    localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1342531096;
endpackage

// File: rtl/frontier_avm_read_port.sv
// frontier_avm_read_port: single-outstanding Avalon-MM read with per-transaction timeout
// Ports: req (hold high for command + response), addr -> avm_address;
//        acc = command accepted, rvalid/rdata = response, tmo = transaction aborted this cycle.
module frontier_avm_read_port #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        addr,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        tmo,
    output logic        acc,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, fin;
    // cnt_q counts cycles already spent in this transaction; the TIMEOUT_CYCLES-th cycle aborts
    // unless its response arrives in that same cycle. The read strobe drops in the abort cycle.
    always_comb begin
        rvalid = req & pend_q & avm_readdatavalid;
        tmo = req & ~rvalid & (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        avm_read = req & ~pend_q & ~tmo;
        acc = avm_read & ~avm_waitrequest;
        fin = ~req | rvalid | tmo;
        cnt_d = fin ? '0 : cnt_q + TMO_W'(1);
        pend_d = ~fin & (pend_q | acc);
    end
    assign avm_address = addr;
    assign rdata = avm_readdata;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/frontier_sysid_reader.sv
// frontier_sysid_reader: reads sysid ID and build timestamp over Avalon-MM and checks them
// Ports: start launches a check; avm_* read initiator; busy/done status; id_value/ts_value
//        captured words; id_ok/ts_ok/sysid_ok/timeout results held until the next start.
// Optional: FRONTIER_SYSID_READER_RETRY_EN retries a failed check up to 3 times and adds retries[1:0].
module frontier_sysid_reader
    import frontier_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        sysid_ok,
`ifdef FRONTIER_SYSID_READER_RETRY_EN
    output logic [1:0]  retries,
`endif
    output logic        timeout
);
    state_t state_q, state_d;
    logic [31:0] id_value_q, ts_value_q, rdata;
    logic id_ok_q, ts_ok_q, sysid_ok_q, timeout_q;
    logic req, addr, rvalid, tmo, acc, id_match, ts_match, again;
    frontier_avm_read_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(TMO_W)) u_port (
        .clock(clock),
        .reset(reset),
        .req(req),
        .addr(addr),
        .rdata(rdata),
        .rvalid(rvalid),
        .tmo(tmo),
        .acc(acc),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );
    assign id_match = id_value_q == EXPECTED_ID;
    assign ts_match = ts_value_q == EXPECTED_TIMESTAMP;
`ifdef FRONTIER_SYSID_READER_RETRY_EN
    logic [1:0] retry_q;
    assign again = (timeout_q | ~id_match | ~ts_match) & (retry_q != 2'd3);
    assign retries = retry_q;
`else
    assign again = 1'b0;
`endif
    always_comb begin
        req = state_q inside {ID_REQ, ID_WAIT, TS_REQ, TS_WAIT};
        addr = (state_q == TS_REQ || state_q == TS_WAIT) ? ADDR_TS : ADDR_ID;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ID_REQ : IDLE;
            ID_REQ:  state_d = tmo ? FIN : acc ? ID_WAIT : ID_REQ;
            ID_WAIT: state_d = tmo ? FIN : rvalid ? TS_REQ : ID_WAIT;
            TS_REQ:  state_d = tmo ? FIN : acc ? TS_WAIT : TS_REQ;
            TS_WAIT: state_d = (tmo | rvalid) ? FIN : TS_WAIT;
            FIN:     state_d = again ? ID_REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            sysid_ok_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FRONTIER_SYSID_READER_RETRY_EN
            retry_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                id_value_q <= '0;
                ts_value_q <= '0;
                id_ok_q <= 1'b0;
                ts_ok_q <= 1'b0;
                sysid_ok_q <= 1'b0;
                timeout_q <= 1'b0;
`ifdef FRONTIER_SYSID_READER_RETRY_EN
                retry_q <= 2'd0;
`endif
            end
            if (state_q == ID_WAIT && rvalid) id_value_q <= rdata;
            if (state_q == TS_WAIT && rvalid) ts_value_q <= rdata;
            if (tmo) timeout_q <= 1'b1;
            if (state_q == FIN) begin
                id_ok_q <= id_match;
                ts_ok_q <= ts_match;
                sysid_ok_q <= id_match & ts_match & ~timeout_q;
                // A retried attempt starts from a clean capture so stale words cannot pass
                if (again) begin
                    id_value_q <= '0;
                    ts_value_q <= '0;
                    timeout_q <= 1'b0;
`ifdef FRONTIER_SYSID_READER_RETRY_EN
                    retry_q <= retry_q + 2'd1;
`endif
                end
            end
        end
    end
    assign busy = state_q != IDLE;
    assign done = (state_q == FIN) & ~again;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;
    assign id_ok = id_ok_q;
    assign ts_ok = ts_ok_q;
    assign sysid_ok = sysid_ok_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_frontier_sysid_reader.sv
// tb_frontier_sysid_reader: directed checks of the sysid reader against a small Avalon slave model
module tb_frontier_sysid_reader;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic avm_address, avm_read, busy, done, id_ok, ts_ok, sysid_ok, timeout;
    logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0, id_value, ts_value;
    logic [5:0] fl;
`ifdef FRONTIER_SYSID_READER_RETRY_EN
    logic [1:0] retries;
    localparam int BAD_C = 20, TMO_C = 36;
`else
    localparam int BAD_C = 5, TMO_C = 9;
`endif
    localparam logic [31:0] GID = 32'd12345, GTS = 32'd1342531096;
    int n_cmp = 0, n_bad = 0;
    int slv_ws = 0, slv_lat = 1, wcnt = 0, pcnt = 0;
    logic paddr = 1'b0, held_a = 1'b0;
    bit hold_chk = 1'b0, stab_en = 1'b0;
    logic [31:0] slv_id = GID, slv_ts = GTS;

    frontier_sysid_reader #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy),
        .done(done),
        .id_value(id_value),
        .ts_value(ts_value),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .sysid_ok(sysid_ok),
`ifdef FRONTIER_SYSID_READER_RETRY_EN
        .retries(retries),
`endif
        .timeout(timeout)
    );

    always #5 clock = ~clock;
    assign fl = {done, busy, id_ok, ts_ok, sysid_ok, timeout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Slave: inputs for a cycle are set at its negedge from that cycle's DUT outputs.
    // slv_ws wait states per command, response slv_lat cycles after accept (0 = never).
    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        if (pcnt == 1) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = paddr ? slv_ts : slv_id;
        end
        if (pcnt != 0) pcnt--;
        if (hold_chk) chk("cmd_stable", 32'({avm_read, avm_address}), 32'({1'b1, held_a}));
        hold_chk = 1'b0;
        avm_waitrequest = 1'b0;
        if (!avm_read) wcnt = 0;
        else if (wcnt < slv_ws) begin
            avm_waitrequest = 1'b1;
            wcnt++;
            hold_chk = stab_en;
            held_a = avm_address;
        end else begin
            wcnt = 0;
            if (slv_lat != 0) begin
                pcnt = slv_lat;
                paddr = avm_address;
            end
        end
    end

    // Returns the cycle index of done, counting the start cycle as 0 (99 if it never came).
    task automatic run(input bit poke, input int sw, output int cyc, output logic [15:0] rh);
        cyc = 99;
        rh = '0;
        start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            start = poke && i == 2;
            if (i == sw) slv_lat = 1;
            if (i < 16) rh[i] = avm_read;
            if (i == 1) chk("busy_next", 32'(busy), 1);
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic post(input string tag, input logic [31:0] ef, input logic [31:0] ei, input logic [31:0] et);
        @(posedge clock);
        #1;
        chk({tag, "_flags"}, 32'(fl), ef);
        chk({tag, "_id"}, id_value, ei);
        chk({tag, "_ts"}, ts_value, et);
    endtask

    initial begin
        int c;
        logic [15:0] rh;
        bit seen;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", 32'({fl, avm_read, avm_address}), 0);
        chk("rst_id", id_value, 0);
        chk("rst_ts", ts_value, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_out", 32'({fl, avm_read}), 0);
        // zero-wait slave, extra start pulse while busy
        run(1'b1, 0, c, rh);
        chk("zw_cyc", c, 5);
        post("zw", 'b001110, GID, GTS);
        @(posedge clock);
        #1;
        chk("zw_no_restart", 32'(busy), 0);
        // three wait states on each command
        slv_ws = 3;
        stab_en = 1'b1;
        run(1'b0, 0, c, rh);
        chk("ws_cyc", c, 11);
        post("ws", 'b001110, GID, GTS);
        stab_en = 1'b0;
        slv_ws = 0;
        // wrong ID word
        slv_id = 32'd12346;
        run(1'b0, 0, c, rh);
        chk("bad_cyc", c, BAD_C);
        post("bad", 'b000100, 32'd12346, GTS);
        slv_id = GID;
        // command accepted, response never arrives
        slv_lat = 0;
        run(1'b0, 0, c, rh);
        chk("nr_cyc", c, TMO_C);
        post("nr", 'b000001, 0, 0);
        slv_lat = 1;
        // waitrequest never released: read drops in the 8th command cycle
        slv_ws = 1000;
        run(1'b0, 0, c, rh);
        chk("ab_cyc", c, TMO_C);
        chk("ab_read", 32'(rh[8:7]), 'b01);
        post("ab", 'b000001, 0, 0);
        slv_ws = 0;
        // reset during ID_WAIT, response arrives after reset release
        slv_lat = 3;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out", 32'({fl, avm_read, avm_address}), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            seen = seen | done | busy;
        end
        chk("late_rsp_ignored", 32'(seen), 0);
        chk("late_rsp_id", id_value, 0);
        slv_lat = 1;
        // recovery after reset
        run(1'b0, 0, c, rh);
        chk("rec_cyc", c, 5);
        post("rec", 'b001110, GID, GTS);
`ifdef FRONTIER_SYSID_READER_RETRY_EN
        // first attempt times out, the retry passes
        slv_lat = 0;
        run(1'b0, 5, c, rh);
        chk("rt_cyc", c, 14);
        post("rt", 'b001110, GID, GTS);
        chk("rt_retries", 32'(retries), 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
